// File: rtl/brush_plotter_if.sv
// Request/pixel-stream bundle between the mouse front end, brush_plotter and the VGA plot port.
// The master drives cursor and button requests; the slave returns the pixel write stream.
interface brush_plotter_if #(
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 240,
    parameter int COLOUR_BITS   = 3,
    parameter int BRUSH_BITS    = 2
);
    localparam int XW = $clog2(SCREEN_WIDTH) + 1;
    localparam int YW = $clog2(SCREEN_HEIGHT) + 1;

    logic                   iClear;
    logic [COLOUR_BITS-1:0] iColour;
    logic [BRUSH_BITS-1:0]  iBrush;
    logic [7:0]             iX_cell;
    logic [7:0]             iY_cell;
    logic                   iLeftbtn;
    logic                   iRightbtn;
    logic [XW-1:0]          oX_pixel;
    logic [YW-1:0]          oY_pixel;
    logic [COLOUR_BITS-1:0] oColour;
    logic                   oPlot;
    logic                   oBusy;
    logic                   oDone;

    modport master (
        output iClear, iColour, iBrush, iX_cell, iY_cell, iLeftbtn, iRightbtn,
        input  oX_pixel, oY_pixel, oColour, oPlot, oBusy, oDone
    );

    modport slave (
        input  iClear, iColour, iBrush, iX_cell, iY_cell, iLeftbtn, iRightbtn,
        output oX_pixel, oY_pixel, oColour, oPlot, oBusy, oDone
    );
endinterface

// File: rtl/brush_plotter.sv
// Square-brush plotter: turns cell-level mouse draw/erase/clear requests into a
// clipped, one-pixel-per-cycle raster of registered VGA adapter writes.
module brush_plotter #(
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 240,
    parameter int CELL_WIDTH    = 5,
    parameter int COLOUR_BITS   = 3,
    parameter int BRUSH_BITS    = 2,
    parameter logic [COLOUR_BITS-1:0] BG_COLOUR = {COLOUR_BITS{1'b1}}
) (
    input  logic             iClk,
    input  logic             iResetn,
    brush_plotter_if.slave   bus
);
    localparam int XW   = $clog2(SCREEN_WIDTH) + 1;
    localparam int YW   = $clog2(SCREEN_HEIGHT) + 1;
    // Wide enough for the furthest brush pixel (255 cells plus the largest brush) and the screen size.
    localparam int SPAN = (256 + (2 ** BRUSH_BITS)) * CELL_WIDTH + SCREEN_WIDTH + SCREEN_HEIGHT;
    localparam int AW   = $clog2(SPAN) + 1;

    localparam logic [AW-1:0] ZERO_A   = {AW{1'b0}};
    localparam logic [AW-1:0] ONE_A    = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] CELL_A   = AW'(CELL_WIDTH);
    localparam logic [AW-1:0] WIDTH_A  = AW'(SCREEN_WIDTH);
    localparam logic [AW-1:0] HEIGHT_A = AW'(SCREEN_HEIGHT);

    typedef enum logic [1:0] {IDLE = 2'd0, DRAW = 2'd1, CLEAR = 2'd2, DONE = 2'd3} state_t;

    state_t                 state_r, state_nxt_s;
    logic                   clear_d_r, clear_pend_r;
    logic                   clear_rise_s, clear_req_s;
    logic                   start_draw_s, start_clear_s;
    logic                   req_erase_s, suppress_s;
    logic [COLOUR_BITS-1:0] req_colour_s;

    logic [AW-1:0]          x0_r, y0_r, lim_x_r, lim_y_r, dx_r, dy_r;
    logic [AW-1:0]          x_sum_s, y_sum_s;
    logic                   clip_s, row_end_s, scan_end_s;
    logic [COLOUR_BITS-1:0] colour_r;
    logic                   op_clear_r;
    logic [7:0]             req_x_r, req_y_r;
    logic [BRUSH_BITS-1:0]  req_brush_r;
    logic                   req_erase_r;

    logic                   last_valid_r, last_erase_r;
    logic [7:0]             last_x_r, last_y_r;
    logic [COLOUR_BITS-1:0] last_colour_r;
    logic [BRUSH_BITS-1:0]  last_brush_r;

    logic [XW-1:0]          x_pix_r;
    logic [YW-1:0]          y_pix_r;
    logic [COLOUR_BITS-1:0] colour_out_r;
    logic                   plot_r, busy_r, done_r;

    assign clear_rise_s = bus.iClear & ~clear_d_r;
    assign clear_req_s  = clear_pend_r | clear_rise_s;
    assign x_sum_s      = x0_r + dx_r;
    assign y_sum_s      = y0_r + dy_r;
    assign clip_s       = (x_sum_s >= WIDTH_A) || (y_sum_s >= HEIGHT_A);
    assign row_end_s    = (dx_r == lim_x_r - ONE_A);
    assign scan_end_s   = row_end_s && (dy_r == lim_y_r - ONE_A);

    // Resolve the button request and compare it against the last completed draw.
    always_comb begin
        req_erase_s  = 1'b0;
        req_colour_s = bus.iColour;
        if (bus.iLeftbtn) begin
            req_erase_s  = 1'b0;
            req_colour_s = bus.iColour;
        end else begin
            req_erase_s  = 1'b1;
            req_colour_s = BG_COLOUR;
        end
        suppress_s = last_valid_r && (last_x_r == bus.iX_cell) && (last_y_r == bus.iY_cell)
                     && (last_colour_r == req_colour_s) && (last_brush_r == bus.iBrush)
                     && (last_erase_r == req_erase_s);
    end

    // Next-state decode; requests are only accepted in IDLE, clear first.
    always_comb begin
        state_nxt_s   = state_r;
        start_draw_s  = 1'b0;
        start_clear_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (clear_req_s) begin
                    state_nxt_s   = CLEAR;
                    start_clear_s = 1'b1;
                end else if ((bus.iLeftbtn || bus.iRightbtn) && !suppress_s) begin
                    state_nxt_s  = DRAW;
                    start_draw_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DRAW, CLEAR: begin
                if (scan_end_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Clear edge detector; a pending clear survives until CLEAR is entered.
    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            clear_d_r    <= 1'b0;
            clear_pend_r <= 1'b0;
        end else begin
            clear_d_r <= bus.iClear;
            if (start_clear_s) begin
                clear_pend_r <= 1'b0;
            end else if (clear_rise_s) begin
                clear_pend_r <= 1'b1;
            end
        end
    end

    // Scan origin, extent and counters; a clear is a full-screen scan from the origin.
    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            x0_r <= ZERO_A;  y0_r <= ZERO_A;  lim_x_r <= ZERO_A;  lim_y_r <= ZERO_A;
            dx_r <= ZERO_A;  dy_r <= ZERO_A;
            colour_r    <= {COLOUR_BITS{1'b0}};
            op_clear_r  <= 1'b0;
            req_x_r     <= 8'd0;
            req_y_r     <= 8'd0;
            req_brush_r <= {BRUSH_BITS{1'b0}};
            req_erase_r <= 1'b0;
        end else if (start_clear_s) begin
            x0_r <= ZERO_A;  y0_r <= ZERO_A;  lim_x_r <= WIDTH_A;  lim_y_r <= HEIGHT_A;
            dx_r <= ZERO_A;  dy_r <= ZERO_A;
            colour_r   <= BG_COLOUR;
            op_clear_r <= 1'b1;
        end else if (start_draw_s) begin
            x0_r    <= AW'(bus.iX_cell) * CELL_A;
            y0_r    <= AW'(bus.iY_cell) * CELL_A;
            lim_x_r <= (AW'(bus.iBrush) + ONE_A) * CELL_A;
            lim_y_r <= (AW'(bus.iBrush) + ONE_A) * CELL_A;
            dx_r    <= ZERO_A;
            dy_r    <= ZERO_A;
            colour_r    <= req_colour_s;
            op_clear_r  <= 1'b0;
            req_x_r     <= bus.iX_cell;
            req_y_r     <= bus.iY_cell;
            req_brush_r <= bus.iBrush;
            req_erase_r <= req_erase_s;
        end else if ((state_r == DRAW) || (state_r == CLEAR)) begin
            if (row_end_s) begin
                dx_r <= ZERO_A;
                dy_r <= dy_r + ONE_A;
            end else begin
                dx_r <= dx_r + ONE_A;
            end
        end
    end

    // Repeat-suppression memory: written on draw completion, invalidated by a finished clear.
    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            last_valid_r  <= 1'b0;
            last_erase_r  <= 1'b0;
            last_x_r      <= 8'd0;
            last_y_r      <= 8'd0;
            last_colour_r <= {COLOUR_BITS{1'b0}};
            last_brush_r  <= {BRUSH_BITS{1'b0}};
        end else if (state_r == DONE) begin
            if (op_clear_r) begin
                last_valid_r <= 1'b0;
            end else begin
                last_valid_r  <= 1'b1;
                last_erase_r  <= req_erase_r;
                last_x_r      <= req_x_r;
                last_y_r      <= req_y_r;
                last_colour_r <= colour_r;
                last_brush_r  <= req_brush_r;
            end
        end
    end

    // Registered pixel stream: outputs lag the scan counters by one edge.
    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            x_pix_r <= {XW{1'b0}};  y_pix_r <= {YW{1'b0}};  colour_out_r <= {COLOUR_BITS{1'b0}};
            plot_r  <= 1'b0;  busy_r <= 1'b0;  done_r <= 1'b0;
        end else begin
            case (state_r)
                DRAW, CLEAR: begin
                    x_pix_r      <= XW'(x_sum_s);
                    y_pix_r      <= YW'(y_sum_s);
                    colour_out_r <= colour_r;
                    plot_r       <= ~clip_s;
                    busy_r       <= 1'b1;
                    done_r       <= 1'b0;
                end
                DONE: begin
                    x_pix_r <= {XW{1'b0}};  y_pix_r <= {YW{1'b0}};  colour_out_r <= {COLOUR_BITS{1'b0}};
                    plot_r  <= 1'b0;  busy_r <= 1'b0;  done_r <= 1'b1;
                end
                default: begin
                    x_pix_r <= {XW{1'b0}};  y_pix_r <= {YW{1'b0}};  colour_out_r <= {COLOUR_BITS{1'b0}};
                    plot_r  <= 1'b0;  busy_r <= 1'b0;  done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oX_pixel = x_pix_r;
    assign bus.oY_pixel = y_pix_r;
    assign bus.oColour  = colour_out_r;
    assign bus.oPlot    = plot_r;
    assign bus.oBusy    = busy_r;
    assign bus.oDone    = done_r;
endmodule

// File: tb/tb_brush_plotter.sv
// Directed bench for brush_plotter: draw, erase, clipping, suppression, clear and reset abort.
module tb_brush_plotter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    brush_plotter_if bus ();
    brush_plotter dut (.iClk(clk), .iResetn(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;
    int n_plot, n_busy, n_done, n_bad_pos, n_bad_col, n_miss, n_clip_bad, first_busy;
    int w_plot, w_busy, w_done;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_cursor(input int cx, input int cy, input int br, input logic [2:0] col);
        bus.iX_cell = 8'(cx);
        bus.iY_cell = 8'(cy);
        bus.iBrush  = 2'(br);
        bus.iColour = col;
    endtask

    task automatic pulse_left();
        bus.iLeftbtn = 1'b1;
        @(negedge clk);
        bus.iLeftbtn = 1'b0;
    endtask

    // Samples each falling edge until oDone (or budget), scoring the stream against the expected raster.
    task automatic capture(input int x0, input int y0, input int w, input int h,
                           input logic [2:0] col, input int clr_at, input int budget);
        int k;
        int ex;
        int ey;
        bit inb;
        bit got_done;
        n_plot = 0; n_done = 0; n_bad_pos = 0; n_bad_col = 0; n_miss = 0; n_clip_bad = 0;
        first_busy = -1;
        k = 0;
        got_done = 1'b0;
        for (int c = 0; c < budget && !got_done; c++) begin
            @(negedge clk);
            if (c == clr_at) bus.iClear = 1'b1;
            if (clr_at >= 0 && c == clr_at + 3) bus.iClear = 1'b0;
            if (bus.oBusy) begin
                if (first_busy < 0) first_busy = c;
                ex  = x0 + (k % w);
                ey  = y0 + (k / w);
                inb = (ex < 320) && (ey < 240) && (k < w * h);
                if (bus.oPlot) begin
                    n_plot++;
                    if (!inb) n_clip_bad++;
                    else if (int'(bus.oX_pixel) != ex || int'(bus.oY_pixel) != ey) n_bad_pos++;
                    if (bus.oColour != col) n_bad_col++;
                end else if (inb) begin
                    n_miss++;
                end
                k++;
            end else if (bus.oPlot) begin
                n_clip_bad++;
            end
            if (bus.oDone) begin
                n_done++;
                got_done = 1'b1;
            end
        end
        n_busy = k;
    endtask

    task automatic idle_watch(input int cycles);
        w_plot = 0; w_busy = 0; w_done = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (bus.oPlot) w_plot++;
            if (bus.oBusy) w_busy++;
            if (bus.oDone) w_done++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.iClear = 1'b0; bus.iLeftbtn = 1'b0; bus.iRightbtn = 1'b0;
        set_cursor(0, 0, 0, 3'b000);
        repeat (3) @(negedge clk);
        check_eq("rst_plot", int'(bus.oPlot), 0);
        check_eq("rst_busy", int'(bus.oBusy), 0);
        check_eq("rst_done", int'(bus.oDone), 0);
        check_eq("rst_xy",   int'(bus.oX_pixel) + int'(bus.oY_pixel) + int'(bus.oColour), 0);
        rst_n = 1'b1;

        // Scenario 1: single 5x5 draw at cell (2,3).
        set_cursor(2, 3, 0, 3'b100);
        idle_watch(3);
        check_eq("t1_pre_busy", w_busy + w_plot + w_done, 0);
        pulse_left();
        check_eq("t1_lat_busy", int'(bus.oBusy), 0);
        capture(10, 15, 5, 5, 3'b100, -1, 40);
        check_eq("t1_plots", n_plot, 25);
        check_eq("t1_busy", n_busy, 25);
        check_eq("t1_done", n_done, 1);
        check_eq("t1_pos", n_bad_pos, 0);
        check_eq("t1_col", n_bad_col, 0);
        check_eq("t1_miss", n_miss, 0);
        check_eq("t1_first", first_busy, 0);
        idle_watch(5);
        check_eq("t1_done_once", w_done + w_plot, 0);

        // Scenario 2: held erase at (0,0) brush 1, then re-press is suppressed.
        set_cursor(0, 0, 1, 3'b010);
        bus.iRightbtn = 1'b1;
        capture(0, 0, 10, 10, 3'b111, -1, 130);
        check_eq("t2_plots", n_plot, 100);
        check_eq("t2_busy", n_busy, 100);
        check_eq("t2_pos", n_bad_pos, 0);
        check_eq("t2_col", n_bad_col, 0);
        idle_watch(10);
        check_eq("t2_held_supp", w_busy, 0);
        bus.iRightbtn = 1'b0;
        idle_watch(3);
        bus.iRightbtn = 1'b1;
        idle_watch(20);
        check_eq("t2_repress_supp", w_busy + w_done, 0);
        bus.iRightbtn = 1'b0;

        // Scenario 3: brush 3 at the bottom-right corner is clipped to 25 pixels.
        set_cursor(63, 47, 3, 3'b101);
        pulse_left();
        capture(315, 235, 20, 20, 3'b101, -1, 450);
        check_eq("t3_busy", n_busy, 400);
        check_eq("t3_plots", n_plot, 25);
        check_eq("t3_clip", n_clip_bad, 0);
        check_eq("t3_miss", n_miss, 0);
        check_eq("t3_pos", n_bad_pos, 0);
        check_eq("t3_done", n_done, 1);

        // Scenario 4: held left draws once; a colour change draws once more.
        set_cursor(4, 4, 0, 3'b010);
        bus.iLeftbtn = 1'b1;
        capture(20, 20, 5, 5, 3'b010, -1, 40);
        check_eq("t4_plots_a", n_plot, 25);
        check_eq("t4_col_a", n_bad_col, 0);
        idle_watch(10);
        check_eq("t4_held_supp", w_busy, 0);
        bus.iColour = 3'b001;
        capture(20, 20, 5, 5, 3'b001, -1, 40);
        check_eq("t4_plots_b", n_plot, 25);
        check_eq("t4_col_b", n_bad_col, 0);
        idle_watch(20);
        check_eq("t4_no_more", w_busy, 0);
        bus.iLeftbtn = 1'b0;

        // Scenario 5: clear mid-draw, full clear, redraw after invalidation, clear beats left.
        set_cursor(2, 3, 0, 3'b100);
        pulse_left();
        capture(10, 15, 5, 5, 3'b100, 10, 40);
        bus.iClear = 1'b0;
        check_eq("t5_draw_plots", n_plot, 25);
        check_eq("t5_draw_done", n_done, 1);
        check_eq("t5_draw_pos", n_bad_pos, 0);
        capture(0, 0, 320, 240, 3'b111, -1, 76900);
        check_eq("t5_clr_plots", n_plot, 76800);
        check_eq("t5_clr_busy", n_busy, 76800);
        check_eq("t5_clr_done", n_done, 1);
        check_eq("t5_clr_pos", n_bad_pos, 0);
        check_eq("t5_clr_col", n_bad_col, 0);
        pulse_left();
        capture(10, 15, 5, 5, 3'b100, -1, 40);
        check_eq("t5_redraw", n_plot, 25);
        set_cursor(5, 5, 0, 3'b100);
        bus.iClear = 1'b1;
        bus.iLeftbtn = 1'b1;
        capture(0, 0, 320, 240, 3'b111, -1, 60);
        check_eq("t5_prio_busy", n_busy, 59);
        check_eq("t5_prio_col", n_bad_col, 0);
        check_eq("t5_prio_pos", n_bad_pos, 0);
        check_eq("t5_prio_first", first_busy, 1);
        #2 rst_n = 1'b0;
        bus.iClear = 1'b0;
        bus.iLeftbtn = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Scenario 6: asynchronous reset in the middle of a draw.
        set_cursor(10, 10, 2, 3'b011);
        pulse_left();
        repeat (5) @(negedge clk);
        check_eq("t6_mid_busy", int'(bus.oBusy), 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_async_plot", int'(bus.oPlot), 0);
        check_eq("t6_async_busy", int'(bus.oBusy), 0);
        check_eq("t6_async_done", int'(bus.oDone), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_watch(30);
        check_eq("t6_after_plot", w_plot, 0);
        check_eq("t6_after_busy", w_busy + w_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
